// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: valid/ready on the way in,
// valid/ready on the way out, plus result flags.
interface alu_mc_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Op;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             OFL;
  logic             Zero;
  logic             DZ;

  modport master (
    output in_valid, A, B, Op, sign, out_ready,
    input  in_ready, out_valid, Out, OFL, Zero, DZ
  );

  modport slave (
    input  in_valid, A, B, Op, sign, out_ready,
    output in_ready, out_valid, Out, OFL, Zero, DZ
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide/remainder behind valid/ready.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_OR,  OP_AND, OP_ROL, OP_SLL, OP_ROR, OP_SRA,
    OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_MUL, OP_DIV, OP_REM, OP_XOR
  } op_t;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  op_t              w_op, r_op;
  logic             w_in_ready, w_accept, w_multi;
  logic [WIDTH-1:0] r_out;
  logic             r_ofl, r_zero, r_dz;

  // Operand copies and iteration state for MUL/DIV/REM.
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_d;
  logic [SW-1:0]    r_cnt;
  logic             r_sign, r_neg_q, r_neg_r, r_dz_pend, r_movf;

  assign w_op       = op_t'(bus.Op);
  assign w_multi    = (w_op == OP_MUL) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.Out       = r_out;
  assign bus.OFL       = r_ofl;
  assign bus.Zero      = r_zero;
  assign bus.DZ        = r_dz;

  // NOTE: every state register uses non-blocking assignment so all flops
  // sample pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Counter starts at WIDTH-1 and ITER exits when it reaches 1; the last of
  // the WIDTH steps is folded into FIX to hit the WIDTH+2 result latency.
  always_comb begin
    // NOTE: default first, so every path assigns w_next and no latch forms.
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                                 w_next = w_multi ? S_PREP : S_DONE;
        else if (r_state == S_DONE && bus.out_ready)  w_next = S_IDLE;
      end
      S_PREP:  w_next = S_ITER;
      S_ITER:  if (r_cnt == SW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle result path.
  logic [WIDTH:0]     w_add, w_sub;
  logic [SW-1:0]      w_sh;
  logic [2*WIDTH-1:0] w_rol_ext, w_ror_ext;
  logic [WIDTH-1:0]   w_sra, w_sc_out;
  logic               w_lt, w_eq, w_sc_ofl;

  assign w_add     = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_sub     = {1'b0, bus.B} - {1'b0, bus.A};
  assign w_sh      = bus.B[SW-1:0];
  assign w_rol_ext = {bus.A, bus.A} << w_sh;
  assign w_ror_ext = {bus.A, bus.A} >> w_sh;
  assign w_sra     = $signed(bus.A) >>> w_sh;
  assign w_eq      = (bus.A == bus.B);
  assign w_lt      = bus.sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);

  always_comb begin
    w_sc_out = '0;
    w_sc_ofl = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sc_out = w_add[WIDTH-1:0];
        w_sc_ofl = bus.sign ? ((bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_add[WIDTH-1] != bus.A[WIDTH-1]))
                            : w_add[WIDTH];
      end
      OP_SUB: begin
        w_sc_out = w_sub[WIDTH-1:0];
        w_sc_ofl = bus.sign ? ((bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_sub[WIDTH-1] != bus.B[WIDTH-1]))
                            : w_sub[WIDTH];
      end
      OP_OR:   w_sc_out = bus.A | bus.B;
      OP_AND:  w_sc_out = bus.A & bus.B;
      OP_XOR:  w_sc_out = bus.A ^ bus.B;
      OP_ROL:  w_sc_out = w_rol_ext[2*WIDTH-1:WIDTH];
      OP_SLL:  w_sc_out = bus.A << w_sh;
      OP_ROR:  w_sc_out = w_ror_ext[WIDTH-1:0];
      OP_SRA:  w_sc_out = w_sra;
      OP_SEQ:  w_sc_out = {{(WIDTH-1){1'b0}}, w_eq};
      OP_SLT:  w_sc_out = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLE:  w_sc_out = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
      OP_SCO:  w_sc_out = {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
      default: ;
    endcase
  end

  // One iteration step: MUL shifts {hi,lo} right after a conditional add,
  // DIV shifts {hi,lo} left and subtracts the divisor when it fits.
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_hi_nx, w_lo_nx, w_quo, w_rem;
  logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_df;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod, w_sprod;
  logic [WIDTH-1:0]   w_fix_out;
  logic               w_fix_ofl, w_fix_dz, w_mul_ofl;

  assign w_mag_a   = (r_sign && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b   = (r_sign && r_b[WIDTH-1]) ? -r_b : r_b;
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_df  = w_div_sh - {1'b0, r_d};
  assign w_qbit    = ~w_div_df[WIDTH];

  always_comb begin
    if (r_op == OP_MUL) begin
      w_hi_nx = w_mul_sum[WIDTH:1];
      w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_nx = w_qbit ? w_div_df[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_qbit};
    end
  end

  assign w_prod    = {w_hi_nx, w_lo_nx};
  assign w_sprod   = r_neg_q ? -w_prod : w_prod;
  assign w_mul_ofl = r_sign ? !((&w_sprod[2*WIDTH-1:WIDTH-1]) || !(|w_sprod[2*WIDTH-1:WIDTH-1]))
                            : (|w_prod[2*WIDTH-1:WIDTH]);
  assign w_quo     = r_neg_q ? -w_lo_nx : w_lo_nx;
  assign w_rem     = r_neg_r ? -w_hi_nx : w_hi_nx;

  always_comb begin
    w_fix_out = w_sprod[WIDTH-1:0];
    w_fix_ofl = w_mul_ofl;
    w_fix_dz  = 1'b0;
    if (r_op == OP_DIV) begin
      w_fix_out = r_dz_pend ? '1 : w_quo;
      w_fix_ofl = r_movf && !r_dz_pend;
      w_fix_dz  = r_dz_pend;
    end else if (r_op == OP_REM) begin
      w_fix_out = r_dz_pend ? r_a : w_rem;
      w_fix_ofl = 1'b0;
      w_fix_dz  = r_dz_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_ofl  <= 1'b0;
      r_zero <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept && !w_multi) begin
      r_out  <= w_sc_out;
      r_ofl  <= w_sc_ofl;
      r_zero <= (w_sc_out == '0);
      r_dz   <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_out  <= w_fix_out;
      r_ofl  <= w_fix_ofl;
      r_zero <= (w_fix_out == '0);
      r_dz   <= w_fix_dz;
    end
  end

  // NOTE: working registers are left unreset; they are always loaded at
  // accept/PREP before use, and only the FSM and visible outputs need rst.
  always_ff @(posedge clk) begin
    if (w_accept && w_multi) begin
      r_a    <= bus.A;
      r_b    <= bus.B;
      r_op   <= w_op;
      r_sign <= bus.sign;
    end
    case (r_state)
      S_PREP: begin
        r_hi      <= '0;
        r_lo      <= w_mag_a;
        r_d       <= w_mag_b;
        r_cnt     <= SW'(WIDTH - 1);
        r_neg_q   <= r_sign && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_neg_r   <= r_sign && r_a[WIDTH-1];
        r_dz_pend <= (r_b == '0);
        r_movf    <= r_sign && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
      end
      S_ITER: begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt - SW'(1);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a reference model queues expected results and
// latencies at accept; a negedge monitor compares them against DUT output.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc_if #(.WIDTH(16)) bus16 ();
  alu_mc_if #(.WIDTH(8))  bus8 ();
  alu_mc_if #(.WIDTH(32)) bus32 ();

  alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    logic [15:0] out;
    logic        ofl;
    logic        zero;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t scb[$];
  bit   seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built on 64-bit integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    exp_t        e;
    longint      sa, sbv, ua, ub, r;
    logic [31:0] t;
    int          sh;
    sa  = s ? longint'($signed(a)) : longint'(a);
    sbv = s ? longint'($signed(b)) : longint'(b);
    ua  = longint'(a);
    ub  = longint'(b);
    sh  = int'(b[3:0]);
    e.out = '0; e.ofl = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'd0:  begin r = sa + sbv; e.out = r[15:0];
                   e.ofl = s ? (r > 32767 || r < -32768) : (ua + ub > 65535); end
      4'd1:  begin r = sbv - sa; e.out = r[15:0];
                   e.ofl = s ? (r > 32767 || r < -32768) : (ua > ub); end
      4'd2:  e.out = a | b;
      4'd3:  e.out = a & b;
      4'd4:  begin t = {a, a} << sh; e.out = t[31:16]; end
      4'd5:  e.out = a << sh;
      4'd6:  begin t = {a, a} >> sh; e.out = t[15:0]; end
      4'd7:  e.out = $signed(a) >>> sh;
      4'd8:  e.out = {15'd0, a == b};
      4'd9:  e.out = {15'd0, sa < sbv};
      4'd10: e.out = {15'd0, sa <= sbv};
      4'd11: e.out = {15'd0, (ua + ub) > 65535};
      4'd12: begin r = sa * sbv; e.out = r[15:0]; e.lat = 18;
                   e.ofl = s ? (r > 32767 || r < -32768) : (r > 65535); end
      4'd13: begin
        e.lat = 18;
        if (b == 16'd0) begin e.out = 16'hFFFF; e.dz = 1'b1; end
        else if (s && a == 16'h8000 && b == 16'hFFFF) begin e.out = 16'h8000; e.ofl = 1'b1; end
        else begin r = sa / sbv; e.out = r[15:0]; end
      end
      4'd14: begin
        e.lat = 18;
        if (b == 16'd0) begin e.out = a; e.dz = 1'b1; end
        else begin r = sa % sbv; e.out = r[15:0]; end
      end
      default: e.out = a ^ b;
    endcase
    e.zero = (e.out == 16'd0);
    return e;
  endfunction

  // Monitor: latency on first sight, then value/stability every cycle held.
  always @(negedge clk) begin
    if (!rst && bus16.out_valid) begin
      if (scb.size() == 0) begin
        check("spurious_result", bus16.out_valid, 1'b0);
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - scb[0].acc), 64'(scb[0].lat));
          seen = 1'b1;
        end
        check("out",  bus16.Out,  scb[0].out);
        check("ofl",  bus16.OFL,  scb[0].ofl);
        check("zero", bus16.Zero, scb[0].zero);
        check("dz",   bus16.DZ,   scb[0].dz);
        check("in_ready_done", bus16.in_ready, bus16.out_ready);
        if (bus16.out_ready) begin
          void'(scb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ordy = 1'b1);
    exp_t e;
    int   waited = 0;
    @(posedge clk); #1;
    bus16.in_valid  = 1'b1;
    bus16.A         = a;
    bus16.B         = b;
    bus16.Op        = op;
    bus16.sign      = s;
    bus16.out_ready = ordy;
    @(negedge clk);
    while (!bus16.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", bus16.in_ready, 1'b1);
    e     = model(op, a, b, s);
    e.acc = cyc;
    scb.push_back(e);
  endtask

  // Drop in_valid and scramble operands to show they are not re-sampled.
  task automatic idle_in();
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.A        = 16'($urandom);
    bus16.B        = 16'($urandom);
    bus16.Op       = 4'($urandom);
    bus16.sign     = 1'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (scb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(scb.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, bus16.out_valid, 1'b0);
    check({tag, "_out"},       bus16.Out, 16'd0);
    check({tag, "_ofl"},       bus16.OFL, 1'b0);
    check({tag, "_zero"},      bus16.Zero, 1'b0);
    check({tag, "_dz"},        bus16.DZ, 1'b0);
    check({tag, "_in_ready"},  bus16.in_ready, 1'b1);
  endtask

  initial begin
    int acc;
    int w;
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Op = '0; bus16.sign = 1'b0;
    bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Op = '0; bus8.sign = 1'b0;
    bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.Op = '0; bus32.sign = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Single-cycle ops, back to back.
    do_op(4'd0,  16'h7FFF, 16'h0001, 1'b1);
    do_op(4'd0,  16'h7FFF, 16'h0001, 1'b0);
    do_op(4'd0,  16'hFFFF, 16'h0002, 1'b0);
    do_op(4'd1,  16'h0005, 16'h0003, 1'b0);
    do_op(4'd1,  16'h8000, 16'h0001, 1'b1);
    do_op(4'd9,  16'hFFFF, 16'h0001, 1'b1);
    do_op(4'd9,  16'hFFFF, 16'h0001, 1'b0);
    do_op(4'd10, 16'h1234, 16'h1234, 1'b0);
    do_op(4'd8,  16'h00AA, 16'h00AB, 1'b0);
    do_op(4'd11, 16'h8000, 16'h8000, 1'b0);
    do_op(4'd2,  16'hF0F0, 16'h0F00, 1'b0);
    do_op(4'd3,  16'hF0F0, 16'h0FF0, 1'b0);
    do_op(4'd15, 16'hAAAA, 16'hAAAA, 1'b0);
    do_op(4'd4,  16'h8001, 16'h0000, 1'b0);
    do_op(4'd4,  16'h8001, 16'hFFF4, 1'b0);
    do_op(4'd6,  16'h8001, 16'h0001, 1'b0);
    do_op(4'd5,  16'h00F1, 16'h0008, 1'b0);
    do_op(4'd7,  16'h8010, 16'h0004, 1'b0);
    idle_in();
    drain();

    // Iterative ops, including divide-by-zero and the most-negative/-1 case.
    do_op(4'd12, 16'hFFFD, 16'h0007, 1'b1); idle_in();
    do_op(4'd12, 16'h0100, 16'h0100, 1'b0); idle_in();
    do_op(4'd12, 16'h4000, 16'h0002, 1'b1); idle_in();
    do_op(4'd12, 16'h8000, 16'hFFFF, 1'b1); idle_in();
    do_op(4'd13, 16'hFFF9, 16'h0002, 1'b1); idle_in();
    do_op(4'd14, 16'hFFF9, 16'h0002, 1'b1); idle_in();
    do_op(4'd13, 16'h8000, 16'hFFFF, 1'b1); idle_in();
    do_op(4'd14, 16'h8000, 16'hFFFF, 1'b1); idle_in();
    do_op(4'd13, 16'h0009, 16'h0000, 1'b0); idle_in();
    do_op(4'd14, 16'h0009, 16'h0000, 1'b0); idle_in();
    do_op(4'd13, 16'hFDE8, 16'h0007, 1'b0); idle_in();
    do_op(4'd14, 16'h0007, 16'hFFFD, 1'b1); idle_in();
    drain();

    // Back-pressure: MUL result held 5 cycles, then released with a new ADD.
    do_op(4'd12, 16'h0123, 16'h0011, 1'b0, 1'b0);
    idle_in();
    w = 0;
    while (!bus16.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("hold_wait", bus16.out_valid, 1'b1);
    repeat (5) @(negedge clk);
    do_op(4'd0, 16'h0010, 16'h0020, 1'b0, 1'b1);

    // Streaming: 8 ADDs, one result per cycle.
    for (int i = 0; i < 8; i++) do_op(4'd0, 16'(i * 1000), 16'(i + 1), 1'b0);
    idle_in();
    drain();

    // Abort a DIV mid-iteration.
    do_op(4'd13, 16'h1234, 16'h0005, 1'b0);
    idle_in();
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    scb.delete();
    seen = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_result", bus16.out_valid, 1'b0);
    end
    do_op(4'd0, 16'h0001, 16'h0002, 1'b0);
    idle_in();
    drain();

    // WIDTH=8 MUL latency.
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.A = 8'd13; bus8.B = 8'd11; bus8.Op = 4'd12; bus8.sign = 1'b0;
    @(negedge clk);
    check("w8_accept", bus8.in_ready, 1'b1);
    acc = cyc;
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    w = 0;
    while (!bus8.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("w8_latency", 64'(cyc - acc), 64'd10);
    check("w8_out", bus8.Out, 8'h8F);
    check("w8_ofl", bus8.OFL, 1'b0);

    // WIDTH=32 MUL latency.
    @(posedge clk); #1;
    bus32.in_valid = 1'b1; bus32.A = 32'hFFFF_FFFD; bus32.B = 32'd7; bus32.Op = 4'd12;
    bus32.sign = 1'b1;
    @(negedge clk);
    check("w32_accept", bus32.in_ready, 1'b1);
    acc = cyc;
    @(posedge clk); #1 bus32.in_valid = 1'b0;
    w = 0;
    while (!bus32.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("w32_latency", 64'(cyc - acc), 64'd34);
    check("w32_out", bus32.Out, 32'hFFFF_FFEB);
    check("w32_ofl", bus32.OFL, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
